// File: rtl/mult_unit_if.sv
// Request/response bundle between the ALU multiplier port and mult_unit.
// master = ALU/datapath side, slave = multiplier side.
interface mult_unit_if #(
   parameter int WIDTH = 32
);
   logic             en_mult;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product_hi;
   logic [WIDTH-1:0] product_lo;

   modport master (
      output en_mult, is_signed, a, b,
      input  busy, done, product_hi, product_lo
   );

   modport slave (
      input  en_mult, is_signed, a, b,
      output busy, done, product_hi, product_lo
   );
endinterface

// File: rtl/mult_unit.sv
// Radix-2 shift-add multiplier, IDLE/RUN/DONE sequencing, sign applied at completion.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic        clock,
   input  logic        reset,
   mult_unit_if.slave  mul_io
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               sign_q, sign_d;

   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] acc_sum;
   logic               last_iter;

   assign addend  = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
   assign acc_sum = acc_q + addend;

`ifdef MULT_EARLY_EXIT_EN
   // done once nothing is left after this iteration's shift
   assign last_iter = (mplier_q[WIDTH-1:1] == '0);
`else
   assign last_iter = (cnt_q == CW'(WIDTH - 1));
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      sign_d   = sign_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (mul_io.en_mult) begin
               state_d  = RUN;
               // |0x80..0| stays 0x80..0, which is correct read as unsigned
               mcand_d  = (mul_io.is_signed && mul_io.a[WIDTH-1]) ? -mul_io.a : mul_io.a;
               mplier_d = (mul_io.is_signed && mul_io.b[WIDTH-1]) ? -mul_io.b : mul_io.b;
               sign_d   = mul_io.is_signed & (mul_io.a[WIDTH-1] ^ mul_io.b[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
            end
         end
         RUN: begin
            acc_d    = acc_sum;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last_iter) begin
               state_d = DONE;
               prod_d  = sign_q ? -acc_sum : acc_sum;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mul_io.busy       = (state_q == RUN);
   assign mul_io.done       = (state_q == DONE);
   assign mul_io.product_hi = prod_q[2*WIDTH-1:WIDTH];
   assign mul_io.product_lo = prod_q[WIDTH-1:0];
endmodule

// File: tb/tb_mult_unit.sv
// Directed + randomized bench for mult_unit; reference is plain 64-bit arithmetic.
module tb_mult_unit;
   localparam int W = 32;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mult_unit_if #(.WIDTH(W)) bus ();
   mult_unit #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .mul_io(bus));

   int          ncmp = 0;
   int          nerr = 0;
   logic [63:0] last_prod;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_prod(input bit s, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = {32'b0, a};
      ub = {32'b0, b};
      return ua * ub;
   endfunction

   function automatic int ref_lat(input bit s, input logic [31:0] b);
      logic [31:0] m;
      int          n;
      m = (s && b[31]) ? 32'(-b) : b;
      n = W;
`ifdef MULT_EARLY_EXIT_EN
      n = 1;
      for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
`endif
      return n;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [63:0] prod_now();
      return {bus.product_hi, bus.product_lo};
   endfunction

   task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b);
      bus.en_mult   = 1'b1;
      bus.is_signed = s;
      bus.a         = a;
      bus.b         = b;
      step();
      bus.en_mult   = 1'b0;
      bus.is_signed = 1'($urandom);
      bus.a         = $urandom;
      bus.b         = $urandom;
      chk("busy_after_start", 64'(bus.busy), 64'd1);
      chk("stale_product", prod_now(), last_prod);
   endtask

   task automatic wait_done(input string tag, input bit s, input logic [31:0] a,
                            input logic [31:0] b, input bit inject);
      int          lat, cyc, busyc, inj;
      logic [63:0] exp;
      lat   = ref_lat(s, b);
      exp   = ref_prod(s, a, b);
      inj   = (lat > 10) ? 10 : lat - 1;
      cyc   = 0;
      busyc = 0;
      while (!bus.done && cyc < 200) begin
         if (bus.busy) busyc++;
         if (inject && cyc == inj) begin
            bus.en_mult = 1'b1;
            bus.a       = 32'd9;
            bus.b       = 32'd9;
         end
         step();
         bus.en_mult = 1'b0;
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(lat));
      chk({tag, "_busy_cycles"}, 64'(busyc), 64'(lat));
      chk({tag, "_done"}, 64'(bus.done), 64'd1);
      chk({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
      chk({tag, "_product"}, prod_now(), exp);
      last_prod = exp;
   endtask

   task automatic run_op(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
      start_op(s, a, b);
      wait_done(tag, s, a, b, 1'b0);
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk("idle_done", 64'(bus.done), 64'd0);
         chk("idle_busy", 64'(bus.busy), 64'd0);
         chk("idle_hold", prod_now(), last_prod);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      bit          s;
      logic [31:0] ra, rb;

      reset         = 1'b1;
      bus.en_mult   = 1'b0;
      bus.is_signed = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      last_prod     = '0;
      step();
      step();
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_product", prod_now(), 64'd0);
      reset = 1'b0;
      gap(2);

      // T1..T3
      run_op("t1_u7x6", 1'b0, 32'd7, 32'd6);
      chk("t1_lo", 64'(bus.product_lo), 64'h2A);
      gap(1);
      run_op("t2_s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5);
      chk("t2_const", prod_now(), 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("t2_u_m3x5", 1'b0, 32'hFFFF_FFFD, 32'd5);
      chk("t2u_const", prod_now(), 64'h0000_0004_FFFF_FFF1);
      run_op("t3_umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("t3u_const", prod_now(), 64'hFFFF_FFFE_0000_0001);
      run_op("t3_smin", 1'b1, 32'h8000_0000, 32'h8000_0000);
      chk("t3s_const", prod_now(), 64'h4000_0000_0000_0000);
      run_op("s_min_x_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      gap(1);

      // T4: pulse while busy is ignored, then start from the DONE cycle
      start_op(1'b0, 32'd2, 32'd3);
      wait_done("t4_ignore", 1'b0, 32'd2, 32'd3, 1'b1);
      chk("t4_lo", 64'(bus.product_lo), 64'd6);
      run_op("t4_b2b", 1'b0, 32'd4, 32'd4);
      chk("t4b_lo", 64'(bus.product_lo), 64'd16);
      gap(2);

      // T5: reset in the middle of a run
      run_op("t5_pre", 1'b0, 32'd7, 32'd6);
      start_op(1'b0, 32'd5, 32'd5);
      n = (ref_lat(1'b0, 32'd5) > 12) ? 11 : ref_lat(1'b0, 32'd5) - 1;
      for (int i = 0; i < n; i++) step();
      chk("t5_busy_before_reset", 64'(bus.busy), 64'd1);
      reset = 1'b1;
      #1;
      chk("t5_busy", 64'(bus.busy), 64'd0);
      chk("t5_done", 64'(bus.done), 64'd0);
      chk("t5_product", prod_now(), 64'd0);
      step();
      reset     = 1'b0;
      last_prod = '0;
      run_op("t5_post", 1'b0, 32'd2, 32'd2);
      chk("t5_lo", 64'(bus.product_lo), 64'd4);
      gap(1);

      // T6: latency depends on MULT_EARLY_EXIT_EN through ref_lat
      run_op("t6_3x5", 1'b0, 32'd3, 32'd5);
      gap(1);
      run_op("t6_bzero", 1'b0, 32'd7, 32'd0);
      run_op("t6_neg_b", 1'b1, 32'd11, 32'hFFFF_FFFE);
      gap(1);

      // randomized operands, signedness and idle gaps
      for (int k = 0; k < 40; k++) begin
         s  = 1'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 4))
            0: rb = rb >> $urandom_range(0, 31);
            1: ra = 32'h8000_0000;
            2: rb = 32'($urandom_range(0, 3));
            default: ;
         endcase
         run_op("rand", s, ra, rb);
         gap($urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
